// File: rtl/mackerel_bus_pkg.sv
// -----------------------------------------------------------------------------
// mackerel_bus_pkg
// Shared types and constants for the Mackerel 68000 bus controller.
//   cyc_state_t : bus-cycle FSM states
//   region_t    : decoded target of the current bus cycle
//   FC_IACK     : function code of the CPU interrupt-acknowledge space
//   DECODE_LSB  : lowest CPU address bit seen by the decoder
//   ROM/IO match: value of the lowest decoded address bit for the ROM and IO
//                 windows (all higher decoded bits are 1 for both)
// -----------------------------------------------------------------------------
package mackerel_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_ERR
   } cyc_state_t;

   typedef enum logic [2:0] {
      RGN_ROM,
      RGN_RAM,
      RGN_IO,
      RGN_IACK_VEC,
      RGN_IACK_AUTO,
      RGN_NONE
   } region_t;

   localparam logic [2:0]  FC_IACK       = 3'd7;
   localparam int          DECODE_LSB    = 15;
   localparam logic        ROM_LSB_MATCH = 1'b1;
   localparam logic        IO_LSB_MATCH  = 1'b0;
   localparam int          BOOT_CNT_W    = 8;

endpackage

// File: rtl/mackerel_boot_overlay.sv
// -----------------------------------------------------------------------------
// mackerel_boot_overlay
// Counts CPU bus cycles after reset and raises a sticky BOOT flag once the
// first BOOT_CYCLES cycles have completed.
//   CLK  in  : CPU clock
//   RST  in  : asynchronous reset, active-low
//   AS   in  : address strobe, active-low
//   BOOT out : 0 while ROM is overlaid at address 0, 1 afterwards
// -----------------------------------------------------------------------------
module mackerel_boot_overlay
   import mackerel_bus_pkg::*;
#(
   parameter int BOOT_CYCLES = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic AS,
   output logic BOOT
);

   localparam logic [BOOT_CNT_W-1:0] BOOT_LIMIT = BOOT_CNT_W'(BOOT_CYCLES);
   localparam logic [BOOT_CNT_W-1:0] CNT_MAX    = '1;

   logic                  as_q;
   logic [BOOT_CNT_W-1:0] cyc_cnt;
   logic                  as_fall;

   // A new bus cycle starts where AS was high last clock and is low now.
   assign as_fall = as_q & ~AS;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         as_q    <= 1'b1;
         cyc_cnt <= '0;
         BOOT    <= 1'b0;
      end else begin
         as_q <= AS;
         if (as_fall && (cyc_cnt != CNT_MAX))
            cyc_cnt <= cyc_cnt + 1'b1;
         // Leave the overlay only between cycles, never inside one.
         if (AS && (cyc_cnt >= BOOT_LIMIT))
            BOOT <= 1'b1;
      end
   end

endmodule

// File: rtl/mackerel_bus_controller.sv
// -----------------------------------------------------------------------------
// mackerel_bus_controller
// Address/function-code decoder, boot ROM overlay, wait-state DTACK generator,
// interrupt-acknowledge decoder and bus-cycle timeout for the Mackerel board.
//   CLK, RST  in : clock, asynchronous active-low reset
//   ADDR      in : CPU A[ADDR_W-1:15]
//   A_LO      in : CPU A3..A1 (interrupt level during IACK)
//   FC        in : CPU function codes
//   AS        in : address strobe, active-low
//   DTACK_IO  in : I/O device acknowledge, active-low
//   ROMEN, RAMEN[RAM_BANKS-1:0], IOEN out : chip selects, active-low
//   IACK      out: interrupt acknowledge to the I/O device, active-low
//   DTACK, BERR, VPA out : CPU handshake, active-low
//   BOOT      out: 0 while the ROM overlay is active
// -----------------------------------------------------------------------------
module mackerel_bus_controller
   import mackerel_bus_pkg::*;
#(
   parameter int ADDR_W        = 22,
   parameter int RAM_BANKS     = 2,
   parameter int RAM_BANK_BITS = 19,
   parameter int BOOT_CYCLES   = 8,
   parameter int ROM_WAIT      = 2,
   parameter int RAM_WAIT      = 0,
   parameter int TIMEOUT       = 255,
   parameter int IO_IRQ_LEVEL  = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [ADDR_W-16:0]   ADDR,
   input  logic [2:0]           A_LO,
   input  logic [2:0]           FC,
   input  logic                 AS,
   input  logic                 DTACK_IO,
   output logic                 ROMEN,
   output logic [RAM_BANKS-1:0] RAMEN,
   output logic                 IOEN,
   output logic                 IACK,
   output logic                 DTACK,
   output logic                 BERR,
   output logic                 VPA,
   output logic                 BOOT
);

   localparam int         FIELD_W    = ADDR_W - DECODE_LSB;
   localparam int         BANK_LSB   = RAM_BANK_BITS - DECODE_LSB;
   localparam int         BANK_W     = ADDR_W - RAM_BANK_BITS;
   localparam logic [2:0] IRQ_LVL    = 3'(IO_IRQ_LEVEL);
   localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
   localparam logic [9:0] TMO_LIMIT  = 10'(TIMEOUT);

   function automatic region_t decode_region(
      input logic [FIELD_W-1:0] f_addr,
      input logic [2:0]         f_fc,
      input logic [2:0]         f_lvl,
      input logic               f_boot
   );
      region_t rgn_v;
      if (f_fc == FC_IACK)
         rgn_v = (f_lvl == IRQ_LVL) ? RGN_IACK_VEC : RGN_IACK_AUTO;
      else if (!f_boot)
         rgn_v = RGN_ROM;
      else if (&f_addr[FIELD_W-1:1] && (f_addr[0] == ROM_LSB_MATCH))
         rgn_v = RGN_ROM;
      else if (&f_addr[FIELD_W-1:1] && (f_addr[0] == IO_LSB_MATCH))
         rgn_v = RGN_IO;
      else if (int'(f_addr[FIELD_W-1:BANK_LSB]) < RAM_BANKS)
         rgn_v = RGN_RAM;
      else
         rgn_v = RGN_NONE;
      return rgn_v;
   endfunction

   logic       boot_flag;
   logic       cyc_act;
   logic       acked;
   region_t    rgn, rgn_q, rgn_d;
   cyc_state_t state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [9:0] tmo_q, tmo_d;

   mackerel_boot_overlay #(
      .BOOT_CYCLES (BOOT_CYCLES)
   ) u_boot (
      .CLK  (CLK),
      .RST  (RST),
      .AS   (AS),
      .BOOT (boot_flag)
   );

   assign BOOT = boot_flag;
   assign rgn  = decode_region(ADDR, FC, A_LO, boot_flag);

   // Every strobe is gated by AS and by reset so all outputs idle high the
   // instant AS rises or RST falls, independent of the registered state.
   assign cyc_act = ~AS & RST;

   assign ROMEN = ~(cyc_act && (rgn == RGN_ROM));
   assign IOEN  = ~(cyc_act && (rgn == RGN_IO));
   assign IACK  = ~(cyc_act && (rgn == RGN_IACK_VEC));

   for (genvar k = 0; k < RAM_BANKS; k++) begin : g_ramen
      assign RAMEN[k] = ~(cyc_act && (rgn == RGN_RAM) &&
                          (ADDR[FIELD_W-1:BANK_LSB] == BANK_W'(k)));
   end

   // Vectored IACK passes the device acknowledge straight through; the FSM
   // still tracks the cycle so it times out if the device never answers.
   assign DTACK = ~(cyc_act &&
                    (((state_q == ST_ACK) && (rgn_q != RGN_IACK_AUTO)) ||
                     ((rgn == RGN_IACK_VEC) && !DTACK_IO && (state_q != ST_ERR))));
   // Autovector is requested from the first edge of the cycle onwards.
   assign VPA   = ~(cyc_act && (rgn_q == RGN_IACK_AUTO) &&
                    ((state_q == ST_WAIT) || (state_q == ST_ACK)));
   assign BERR  = ~(cyc_act && (state_q == ST_ERR));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         rgn_q   <= RGN_NONE;
         wait_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         rgn_q   <= rgn_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      rgn_d   = rgn_q;
      wait_d  = wait_q;
      tmo_d   = tmo_q;
      acked   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (!AS) begin
               rgn_d   = rgn;
               wait_d  = (rgn == RGN_ROM) ? ROM_WAIT_C :
                         (rgn == RGN_RAM) ? RAM_WAIT_C : 4'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + 10'd1;
            unique case (rgn_q)
               RGN_ROM, RGN_RAM: begin
                  acked = (wait_q == 4'd0);
                  if (!acked)
                     wait_d = wait_q - 4'd1;
               end
               RGN_IO, RGN_IACK_VEC: acked = !DTACK_IO;
               RGN_IACK_AUTO:        acked = 1'b1;
               default:              acked = 1'b0;
            endcase
            // Acknowledge is tested before timeout so it wins a tie.
            if (AS)
               state_d = ST_IDLE;
            else if (acked)
               state_d = ST_ACK;
            else if (tmo_d == TMO_LIMIT)
               state_d = ST_ERR;
         end
         ST_ACK, ST_ERR: begin
            if (AS)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mackerel_bus_controller.sv
module tb_mackerel_bus_controller;

   localparam int ADDR_W        = 22;
   localparam int RAM_BANKS     = 2;
   localparam int RAM_BANK_BITS = 19;
   localparam int BOOT_CYCLES   = 8;
   localparam int ROM_WAIT      = 2;
   localparam int RAM_WAIT      = 0;
   localparam int TIMEOUT       = 255;
   localparam int IO_IRQ_LEVEL  = 6;
   localparam int BUDGET        = 300;

   // Region labels of the reference model.
   localparam int K_ROM = 0, K_RAM = 1, K_IO = 2, K_VEC = 3, K_AUTO = 4, K_NONE = 5;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [6:0] ADDR = '0;
   logic [2:0] A_LO = '0;
   logic [2:0] FC = 3'd6;
   logic       AS = 1'b1;
   logic       DTACK_IO = 1'b1;
   logic       ROMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT;
   logic [1:0] RAMEN;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc_done = 0;   // completed bus cycles since the last reset

   always #5 CLK = ~CLK;

   mackerel_bus_controller #(
      .ADDR_W(ADDR_W), .RAM_BANKS(RAM_BANKS), .RAM_BANK_BITS(RAM_BANK_BITS),
      .BOOT_CYCLES(BOOT_CYCLES), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT),
      .TIMEOUT(TIMEOUT), .IO_IRQ_LEVEL(IO_IRQ_LEVEL)
   ) dut (
      .CLK(CLK), .RST(RST), .ADDR(ADDR), .A_LO(A_LO), .FC(FC), .AS(AS),
      .DTACK_IO(DTACK_IO), .ROMEN(ROMEN), .RAMEN(RAMEN), .IOEN(IOEN),
      .IACK(IACK), .DTACK(DTACK), .BERR(BERR), .VPA(VPA), .BOOT(BOOT)
   );

   // ---------------- reference model ----------------
   function automatic int model_region(input logic [6:0] a, input logic [2:0] fc,
                                       input logic [2:0] lvl, input bit boot);
      int byte_addr;
      byte_addr = int'(a) * 32'h8000;
      if (fc == 3'd7) return (int'(lvl) == IO_IRQ_LEVEL) ? K_VEC : K_AUTO;
      if (!boot) return K_ROM;
      if (byte_addr == 32'h3F8000) return K_ROM;
      if (byte_addr == 32'h3F0000) return K_IO;
      if (byte_addr / (1 << RAM_BANK_BITS) < RAM_BANKS) return K_RAM;
      return K_NONE;
   endfunction

   // Expected {ROMEN, RAMEN[1:0], IOEN, IACK} with AS low.
   function automatic logic [4:0] model_sel(input int k, input logic [6:0] a);
      logic [4:0] s;
      int bank;
      s = 5'b11111;
      bank = (int'(a) * 32'h8000) / (1 << RAM_BANK_BITS);
      if (k == K_ROM) s[4] = 1'b0;
      if (k == K_RAM) s[2 + bank] = 1'b0;
      if (k == K_IO)  s[1] = 1'b0;
      if (k == K_VEC) s[0] = 1'b0;
      return s;
   endfunction

   function automatic int model_lat(input int k, input int io_at);
      case (k)
         K_ROM:        return ROM_WAIT + 1;
         K_RAM:        return RAM_WAIT + 1;
         K_IO, K_VEC:  return io_at;
         K_AUTO:       return 0;
         default:      return TIMEOUT;
      endcase
   endfunction

   // Expected {DTACK, BERR, VPA} when the cycle terminates.
   function automatic logic [2:0] model_term(input int k);
      if (k == K_AUTO) return 3'b110;
      if (k == K_NONE) return 3'b101;
      return 3'b011;
   endfunction

   function automatic bit boot_exp();
      return cyc_done >= BOOT_CYCLES;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic begin_cycle(input logic [6:0] a, input logic [2:0] fc, input logic [2:0] lvl);
      ADDR = a; FC = fc; A_LO = lvl; DTACK_IO = 1'b1; AS = 1'b0;
      #1;
   endtask

   task automatic end_cycle();
      AS = 1'b1; DTACK_IO = 1'b1;
      step();
      cyc_done++;
   endtask

   // Edges counted from E0 = 0; io_at is the edge that first samples DTACK_IO low.
   task automatic wait_term(input int io_at, output int lat, output logic [2:0] term);
      lat = -1;
      term = 3'b111;
      for (int k = 0; k < BUDGET; k++) begin
         if (k == io_at) DTACK_IO = 1'b0;
         step();
         if (!DTACK || !BERR || !VPA) begin
            lat = k;
            term = {DTACK, BERR, VPA};
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b0; AS = 1'b1;
      step(); step();
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT} !== 9'b1_1111_1110) begin
         $display("FAIL reset_idle: got %b expected %b",
                  {ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT}, 9'b1_1111_1110);
      end else pass_cnt++;
      ADDR = '0; FC = 3'd6; AS = 1'b0; #1;
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT} !== 9'b1_1111_1110) begin
         $display("FAIL reset_as_low: got %b expected %b",
                  {ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT}, 9'b1_1111_1110);
      end else pass_cnt++;
      AS = 1'b1;
      step();
      RST = 1'b1;
      cyc_done = 0;
      step();
   endtask

   task automatic test_boot();
      int lat;
      logic [2:0] term;
      int k;
      for (int i = 1; i <= BOOT_CYCLES + 1; i++) begin
         k = model_region(7'h00, 3'd6, 3'd0, boot_exp());
         begin_cycle(7'h00, 3'd6, 3'd0);
         chk_cnt++;
         if ({ROMEN, RAMEN, IOEN, IACK} !== model_sel(k, 7'h00)) begin
            $display("FAIL boot_sel cycle %0d: got %b expected %b", i,
                     {ROMEN, RAMEN, IOEN, IACK}, model_sel(k, 7'h00));
         end else pass_cnt++;
         wait_term(-1, lat, term);
         chk_cnt++;
         if (lat !== model_lat(k, -1) || term !== model_term(k)) begin
            $display("FAIL boot_ack cycle %0d: got lat %0d term %b expected lat %0d term %b",
                     i, lat, term, model_lat(k, -1), model_term(k));
         end else pass_cnt++;
         end_cycle();
         chk_cnt++;
         if (BOOT !== boot_exp()) begin
            $display("FAIL boot_flag after cycle %0d: got %b expected %b", i, BOOT, boot_exp());
         end else pass_cnt++;
      end
   endtask

   task automatic test_ram_bank();
      begin_cycle(7'h10, 3'd5, 3'd0);   // 0x080000
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK} !== 5'b1_01_11) begin
         $display("FAIL ram_bank1_sel: got %b expected %b", {ROMEN, RAMEN, IOEN, IACK}, 5'b1_01_11);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if (DTACK !== 1'b1) $display("FAIL ram_dtack_e0: got %b expected 1", DTACK);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (DTACK !== 1'b0) $display("FAIL ram_dtack_e1: got %b expected 0", DTACK);
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_rom_wait();
      begin_cycle(7'h7F, 3'd6, 3'd0);   // 0x3F8000
      for (int e = 0; e < ROM_WAIT + 1; e++) begin
         step();
         chk_cnt++;
         if (DTACK !== 1'b1 || ROMEN !== 1'b0) begin
            $display("FAIL rom_wait edge %0d: got dtack %b romen %b expected 1 0", e, DTACK, ROMEN);
         end else pass_cnt++;
      end
      step();
      chk_cnt++;
      if (DTACK !== 1'b0) $display("FAIL rom_dtack: got %b expected 0", DTACK);
      else pass_cnt++;
      AS = 1'b1; #1;
      chk_cnt++;
      if (DTACK !== 1'b1) $display("FAIL rom_dtack_negate: got %b expected 1", DTACK);
      else pass_cnt++;
      step();
      cyc_done++;
   endtask

   task automatic test_io();
      begin_cycle(7'h7E, 3'd5, 3'd0);   // 0x3F0000
      for (int e = 0; e < 5; e++) begin
         step();
         chk_cnt++;
         if (DTACK !== 1'b1 || IOEN !== 1'b0) begin
            $display("FAIL io_wait edge %0d: got dtack %b ioen %b expected 1 0", e, DTACK, IOEN);
         end else pass_cnt++;
      end
      DTACK_IO = 1'b0; #1;
      chk_cnt++;
      if (DTACK !== 1'b1) $display("FAIL io_not_passthrough: got %b expected 1", DTACK);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (DTACK !== 1'b0 || IOEN !== 1'b0) begin
         $display("FAIL io_ack: got dtack %b ioen %b expected 0 0", DTACK, IOEN);
      end else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_ack_beats_timeout();
      int lat;
      logic [2:0] term;
      begin_cycle(7'h7E, 3'd5, 3'd0);
      wait_term(TIMEOUT, lat, term);
      chk_cnt++;
      if (lat !== TIMEOUT || term !== 3'b011) begin
         $display("FAIL ack_vs_timeout: got lat %0d term %b expected lat %0d term 011", lat, term, TIMEOUT);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if ({DTACK, BERR} !== 2'b01) $display("FAIL ack_vs_timeout_hold: got %b expected 01", {DTACK, BERR});
      else pass_cnt++;
      end_cycle();
   endtask

   task automatic test_iack();
      begin_cycle(7'h7F, 3'd7, 3'd6);
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK} !== 5'b1_11_10) begin
         $display("FAIL iack_vec_sel: got %b expected %b", {ROMEN, RAMEN, IOEN, IACK}, 5'b1_11_10);
      end else pass_cnt++;
      step(); step();
      chk_cnt++;
      if (DTACK !== 1'b1 || VPA !== 1'b1) $display("FAIL iack_vec_wait: got %b expected 11", {DTACK, VPA});
      else pass_cnt++;
      DTACK_IO = 1'b0;
      step();
      chk_cnt++;
      if (DTACK !== 1'b0 || VPA !== 1'b1) $display("FAIL iack_vec_ack: got %b expected 01", {DTACK, VPA});
      else pass_cnt++;
      end_cycle();

      begin_cycle(7'h00, 3'd7, 3'd3);
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK} !== 5'b1_11_11) begin
         $display("FAIL iack_auto_sel: got %b expected %b", {ROMEN, RAMEN, IOEN, IACK}, 5'b1_11_11);
      end else pass_cnt++;
      step();
      chk_cnt++;
      if ({DTACK, BERR, VPA} !== 3'b110) $display("FAIL iack_auto_e0: got %b expected 110", {DTACK, BERR, VPA});
      else pass_cnt++;
      step(); step();
      chk_cnt++;
      if ({DTACK, BERR, VPA} !== 3'b110) $display("FAIL iack_auto_hold: got %b expected 110", {DTACK, BERR, VPA});
      else pass_cnt++;
      AS = 1'b1; #1;
      chk_cnt++;
      if (VPA !== 1'b1) $display("FAIL iack_auto_negate: got %b expected 1", VPA);
      else pass_cnt++;
      step();
      cyc_done++;
   endtask

   task automatic test_unmapped();
      int lat;
      logic [2:0] term;
      begin_cycle(7'h40, 3'd6, 3'd0);   // 0x200000
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK} !== 5'b1_11_11) begin
         $display("FAIL unmapped_sel: got %b expected 11111", {ROMEN, RAMEN, IOEN, IACK});
      end else pass_cnt++;
      wait_term(-1, lat, term);
      chk_cnt++;
      if (lat !== TIMEOUT || term !== 3'b101) begin
         $display("FAIL unmapped_berr: got lat %0d term %b expected lat %0d term 101", lat, term, TIMEOUT);
      end else pass_cnt++;
      end_cycle();
      chk_cnt++;
      if (BERR !== 1'b1) $display("FAIL unmapped_berr_release: got %b expected 1", BERR);
      else pass_cnt++;
   endtask

   // Back-to-back random cycles: AS high for exactly one edge between them.
   task automatic test_back_to_back_random();
      int kind, k, io_at, lat;
      logic [6:0] a;
      logic [2:0] fc, lvl;
      logic [2:0] term;
      for (int n = 0; n < 30; n++) begin
         kind = $urandom_range(0, 5);
         fc = 3'($urandom_range(0, 6));
         lvl = 3'($urandom_range(0, 7));
         case (kind)
            0:       a = 7'h7F;
            1:       a = 7'($urandom_range(0, RAM_BANKS * 16 - 1));
            2:       a = 7'h7E;
            3, 4:    begin a = 7'($urandom_range(0, 127)); fc = 3'd7; end
            default: a = 7'($urandom_range(32, 125));
         endcase
         k = model_region(a, fc, lvl, boot_exp());
         io_at = (k == K_IO || k == K_VEC) ? $urandom_range(1, 12) : -1;
         begin_cycle(a, fc, lvl);
         chk_cnt++;
         if ({ROMEN, RAMEN, IOEN, IACK} !== model_sel(k, a)) begin
            $display("FAIL rand_sel %0d a=%h fc=%0d lvl=%0d: got %b expected %b", n, a, fc, lvl,
                     {ROMEN, RAMEN, IOEN, IACK}, model_sel(k, a));
         end else pass_cnt++;
         wait_term(io_at, lat, term);
         chk_cnt++;
         if (lat !== model_lat(k, io_at) || term !== model_term(k)) begin
            $display("FAIL rand_term %0d a=%h fc=%0d lvl=%0d: got lat %0d term %b expected lat %0d term %b",
                     n, a, fc, lvl, lat, term, model_lat(k, io_at), model_term(k));
         end else pass_cnt++;
         end_cycle();
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      logic [2:0] term;
      begin_cycle(7'h40, 3'd6, 3'd0);
      repeat (20) step();
      chk_cnt++;
      if ({DTACK, BERR, VPA} !== 3'b111) $display("FAIL mid_wait: got %b expected 111", {DTACK, BERR, VPA});
      else pass_cnt++;
      RST = 1'b0; #1;
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT} !== 9'b1_1111_1110) begin
         $display("FAIL mid_reset: got %b expected %b",
                  {ROMEN, RAMEN, IOEN, IACK, DTACK, BERR, VPA, BOOT}, 9'b1_1111_1110);
      end else pass_cnt++;
      step();
      AS = 1'b1;
      step();
      RST = 1'b1;
      cyc_done = 0;
      step();
      begin_cycle(7'h00, 3'd6, 3'd0);
      chk_cnt++;
      if ({ROMEN, RAMEN, IOEN, IACK} !== model_sel(K_ROM, 7'h00)) begin
         $display("FAIL post_reset_overlay: got %b expected %b", {ROMEN, RAMEN, IOEN, IACK},
                  model_sel(K_ROM, 7'h00));
      end else pass_cnt++;
      wait_term(-1, lat, term);
      chk_cnt++;
      if (lat !== ROM_WAIT + 1 || term !== 3'b011) begin
         $display("FAIL post_reset_ack: got lat %0d term %b expected lat %0d term 011", lat, term, ROM_WAIT + 1);
      end else pass_cnt++;
      end_cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no summary by time limit, required self-termination");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_boot();
      test_ram_bank();
      test_rom_wait();
      test_io();
      test_ack_beats_timeout();
      test_iack();
      test_unmapped();
      test_back_to_back_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
